uart_rx: RTL and testbench

Memory-mapped UART receiver peripheral for the SoC. It deserialises 8N1 frames arriving on the board RX pin and holds the received bytes for the CPU to read with a load from the I/O region. It is the input-direction counterpart to the CPU-driven LED output. The CPU side is a plain ready/pop handshake, so the SoC address decoder only steers a read strobe and muxes `data` and flags onto the load path.

---
 rtl/uart_rx.sv | 161 ++++++++++++++++
 tb/tb_uart_rx.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// 8N1 UART receiver with CPU pop handshake and sticky error flags.
// Define UART_RX_FIFO_EN to replace the single holding register with a 4-entry FIFO.
module uart_rx #(
  parameter int unsigned CLK_FREQ = 27_000_000,
  parameter int unsigned BAUD     = 115200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  input  logic       rd,
  input  logic       err_clr,
  output logic [7:0] data,
  output logic       data_ready,
  output logic       overrun,
  output logic       frame_err
);

  localparam int unsigned CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int unsigned HALF         = CLKS_PER_BIT / 2;
  localparam int unsigned CNT_W        = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} state_t;

  state_t           state, next;
  logic [1:0]       sync;
  logic             rx_s;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shift;
  logic             cnt_clr, shift_en, push_set, ferr_set;
  logic             push, pop, ovr_set;

  always_ff @(posedge clk) begin
    if (!rst) sync <= '1;
    else      sync <= {sync[0], rx};
  end
  assign rx_s = sync[1];

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= next;
  end

  always_comb begin
    next     = state;
    cnt_clr  = 1'b0;
    shift_en = 1'b0;
    push_set = 1'b0;
    ferr_set = 1'b0;
    case (state)
      IDLE: if (!rx_s) begin
        next    = START;
        cnt_clr = 1'b1;
      end
      START: if (cnt == HALF_LAST) begin
        cnt_clr = 1'b1;
        next    = rx_s ? IDLE : DATA;
      end
      DATA: if (cnt == BIT_LAST) begin
        cnt_clr  = 1'b1;
        shift_en = 1'b1;
        if (bit_idx == 3'd7) next = STOP;
      end
      STOP: if (cnt == BIT_LAST) begin
        cnt_clr = 1'b1;
        if (rx_s) begin
          push_set = 1'b1;
          next     = IDLE;
        end else begin
          ferr_set = 1'b1;
          next     = WAIT_HIGH;
        end
      end
      WAIT_HIGH: if (rx_s) next = IDLE;
      default: next = IDLE;
    endcase
  end

  // The push is registered so the byte lands one cycle after the stop sample;
  // shift cannot change in that cycle because a new frame needs START first.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt     <= '0;
      bit_idx <= '0;
      shift   <= '0;
      push    <= 1'b0;
    end else begin
      cnt  <= cnt_clr ? '0 : cnt + CNT_W'(1);
      push <= push_set;
      if (state == START) bit_idx <= '0;
      else if (shift_en)  bit_idx <= bit_idx + 3'd1;
      if (shift_en) shift <= {rx_s, shift[7:1]};
    end
  end

`ifdef UART_RX_FIFO_EN
  logic [7:0] mem [4];
  logic [1:0] wptr, rptr;
  logic [2:0] count;
  logic       accept;

  assign pop        = rd && (count != 3'd0);
  assign accept     = push && ((count != 3'd4) || pop);
  assign ovr_set    = push && !accept;
  assign data       = mem[rptr];
  assign data_ready = (count != 3'd0);

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int unsigned i = 0; i < 4; i++) mem[i] <= '0;
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (accept) begin
        mem[wptr] <= shift;
        wptr      <= wptr + 2'd1;
      end
      if (pop) rptr <= rptr + 2'd1;
      case ({accept, pop})
        2'b10:   count <= count + 3'd1;
        2'b01:   count <= count - 3'd1;
        default: count <= count;
      endcase
    end
  end
`else
  logic [7:0] hold;
  logic       full;

  assign pop        = rd && full;
  assign ovr_set    = push && full && !pop;
  assign data       = hold;
  assign data_ready = full;

  always_ff @(posedge clk) begin
    if (!rst) begin
      hold <= '0;
      full <= 1'b0;
    end else if (push && (!full || pop)) begin
      hold <= shift;
      full <= 1'b1;
    end else if (pop) begin
      full <= 1'b0;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      overrun   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      overrun   <= ovr_set  | (overrun   & ~err_clr);
      frame_err <= ferr_set | (frame_err & ~err_clr);
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: expected bytes are queued at send time and
// checked by a monitor on every CPU read strobe.
module tb_uart_rx;

  localparam int BIT = 234;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       rx = 1'b1;
  logic       rd = 1'b0;
  logic       err_clr = 1'b0;
  logic [7:0] data;
  logic       data_ready, overrun, frame_err;

  int tests = 0;
  int fails = 0;
  int ferr_rises = 0;
  logic ferr_prev = 1'b0;
  logic [7:0] exp_q [$];

  uart_rx #(.CLK_FREQ(27_000_000), .BAUD(115200)) dut (
    .clk(clk), .rst(rst), .rx(rx), .rd(rd), .err_clr(err_clr),
    .data(data), .data_ready(data_ready), .overrun(overrun), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every read strobe must present the oldest expected byte.
  always @(negedge clk) begin
    if (rd && data_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_byte", {24'd0, data}, 32'hFFFF_FFFF);
      end else begin
        chk("rx_byte", {24'd0, data}, {24'd0, exp_q.pop_front()});
      end
    end else if (rd && exp_q.size() != 0) begin
      chk("byte_missing_on_rd", {31'd0, data_ready}, 32'd1);
    end
    if (frame_err && !ferr_prev) ferr_rises++;
    ferr_prev = frame_err;
  end

  task automatic send_byte(input logic [7:0] b, input logic stop);
    @(posedge clk); #1 rx = 1'b0;
    for (int i = 0; i < 8; i++) begin
      repeat (BIT) @(posedge clk);
      #1 rx = b[i];
    end
    repeat (BIT) @(posedge clk);
    #1 rx = stop;
    repeat (BIT) @(posedge clk);
    #1;
  endtask

  task automatic pulse_rd();
    @(posedge clk); #1 rd = 1'b1;
    @(posedge clk); #1 rd = 1'b0;
  endtask

  task automatic pulse_clr();
    @(posedge clk); #1 err_clr = 1'b1;
    @(posedge clk); #1 err_clr = 1'b0;
  endtask

  initial begin
    int n;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    chk("reset_data", {24'd0, data}, 32'h00);
    chk("reset_ready", {31'd0, data_ready}, 32'd0);
    chk("reset_overrun", {31'd0, overrun}, 32'd0);
    chk("reset_frame_err", {31'd0, frame_err}, 32'd0);

    // 0x55 with latency measured from the start edge on rx
    exp_q.push_back(8'h55);
    n = 0;
    fork
      send_byte(8'h55, 1'b1);
      begin
        @(negedge rx);
        while (n < 3000) begin
          @(posedge clk);
          n++;
          @(negedge clk);
          if (data_ready) break;
        end
      end
    join
    chk("latency_0x55", n, 2227);
    @(negedge clk);
    chk("ready_0x55", {31'd0, data_ready}, 32'd1);
    chk("ferr_0x55", {31'd0, frame_err}, 32'd0);
    pulse_rd();
    @(negedge clk);
    chk("ready_after_rd_0x55", {31'd0, data_ready}, 32'd0);

    exp_q.push_back(8'hA5);
    send_byte(8'hA5, 1'b1);
    pulse_rd();
    @(negedge clk);
    chk("ready_after_rd_0xA5", {31'd0, data_ready}, 32'd0);

    // short low glitch must not start a frame
    @(posedge clk); #1 rx = 1'b0;
    repeat (50) @(posedge clk);
    #1 rx = 1'b1;
    repeat (3 * BIT) @(posedge clk);
    @(negedge clk);
    chk("glitch_ready", {31'd0, data_ready}, 32'd0);
    chk("glitch_ferr", {31'd0, frame_err}, 32'd0);

    // stop bit low, then a break of three more bit times
    send_byte(8'h3C, 1'b0);
    repeat (3 * BIT) @(posedge clk);
    #1 rx = 1'b1;
    repeat (BIT) @(posedge clk);
    @(negedge clk);
    chk("ferr_set", {31'd0, frame_err}, 32'd1);
    chk("ferr_once", ferr_rises, 1);
    chk("ferr_ready", {31'd0, data_ready}, 32'd0);
    pulse_clr();
    @(negedge clk);
    chk("ferr_cleared", {31'd0, frame_err}, 32'd0);

`ifdef UART_RX_FIFO_EN
    for (int i = 1; i <= 5; i++) begin
      if (i <= 4) exp_q.push_back(8'(i * 8'h11));
      send_byte(8'(i * 8'h11), 1'b1);
    end
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("overrun_set", {31'd0, overrun}, 32'd1);
    for (int i = 0; i < 4; i++) pulse_rd();
`else
    exp_q.push_back(8'h11);
    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b1);
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("overrun_set", {31'd0, overrun}, 32'd1);
    chk("overrun_kept", {24'd0, data}, 32'h11);
    pulse_rd();
`endif
    @(negedge clk);
    chk("drained_ready", {31'd0, data_ready}, 32'd0);
    pulse_clr();
    @(negedge clk);
    chk("overrun_cleared", {31'd0, overrun}, 32'd0);

    // reset mid bit 4 of 0xF0; upper bits are high so the tail is idle line
    fork
      send_byte(8'hF0, 1'b1);
      begin
        @(negedge rx);
        repeat (5 * BIT + BIT / 2) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        #1 rst = 1'b1;
      end
    join
    @(negedge clk);
    chk("midreset_data", {24'd0, data}, 32'h00);
    chk("midreset_ready", {31'd0, data_ready}, 32'd0);
    exp_q.push_back(8'h7E);
    send_byte(8'h7E, 1'b1);
    @(negedge clk);
    chk("post_reset_ready", {31'd0, data_ready}, 32'd1);
    chk("post_reset_flags", {30'd0, overrun, frame_err}, 32'd0);
    pulse_rd();
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("queue_empty", exp_q.size(), 0);
    chk("final_ready", {31'd0, data_ready}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
